muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage. It owns the architectural HI/LO registers and replaces the single-cycle HI_LO path beside the ALU.
- Takes MULT/MULTU/DIV/DIVU/MTHI/MTLO ops from ID/EX and iterates radix-2 over WIDTH cycles.
- Drives Busy to the hazard/stall logic so IF/ID/EX hold while an op is in flight.
- Exposes HI/LO to the ALU for MFHI/MFLO and to the debug outputs.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- Clk  in  1  pipeline clock (divided clock domain).
- Reset  in  1  synchronous, active-low reset.
- Op_Valid  in  1  op present this cycle.
- Op_Code  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- A  in  WIDTH  rs operand: multiplicand/dividend, or MTHI/MTLO source.
- B  in  WIDTH  rt operand: multiplier/divisor.
- Cancel  in  1  pipeline flush; aborts in-flight op.
- Op_Ready  out  1  equals !Busy.
- Busy  out  1  high whenever state != IDLE.
- Done  out  1  one-cycle pulse when HI/LO are updated by a mult/div.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

Behaviour:
- One clock: all state changes on posedge Clk.
- Reset==0 at an edge, including mid-operation:
  - state=IDLE, HI=0, LO=0, Done=0, counter=0.
  - Internal accumulators cleared.
  - Reset has priority over Cancel and Op_Valid.
- States: IDLE, RUN, FIN.
- IDLE:
  - Op_Valid=1 with a mult/div code at edge E0: latch |A|, |B| (magnitudes for signed ops, raw values for unsigned), result-sign flags and op type; counter=0; go to RUN.
  - MTHI/MTLO: write HI (or LO) = A at that edge, stay IDLE, no Done, no Busy.
  - Code 11x: ignored.
- Op_Valid while Busy is ignored; no queueing. Upstream must hold the op until Op_Ready=1.
- RUN: one iteration per edge, E1..E32 for WIDTH=32.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring shift-subtract. Remainder register is WIDTH+1 bits; quotient shifts in 1 when the trial subtract is non-negative.
  - At the edge where counter==WIDTH-1, go to FIN. The counter does not wrap.
- FIN, edge E33:
  - Apply sign fixups.
    - MULT: negate the 64-bit product if sign(A)!=sign(B).
    - DIV: negate the quotient if the signs differ; the remainder takes the sign of A.
  - Write HI/LO:
    - Mult: HI=product[63:32], LO=product[31:0].
    - Div: LO=quotient, HI=remainder.
  - Set Done=1 for exactly the cycle after E33, go to IDLE.
- Latency: Busy is high from after E0 through the cycle before E33 edge completes (WIDTH+1 cycles). New HI/LO are visible and Done=1 after E33. An op accepted at E33 is legal back-to-back.
- Divide by zero (B=0): full latency still applies. LO=all ones, HI=A for both DIV and DIVU, with no sign fixup.
- Signed overflow, DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0. Full latency, no exception.
- Magnitude of 0x80000000 is 0x80000000 treated as unsigned; no overflow.
- Cancel=1 at an edge while RUN/FIN: go to IDLE, HI/LO unchanged, no Done.
- Cancel=1 in IDLE: it is ignored, and it does not block a same-edge MTHI/MTLO or accept.
- HI/LO change only on: reset, MTHI/MTLO in IDLE, or the FIN edge.
- Done=0 in every other cycle.

Test Plan:
- Reset low mid-RUN (10 cycles after DIVU accept), released 1 cycle later -> next cycle: Busy=0, Done=0, HI=0, LO=0; a new MULTU 6*7 completes normally with LO=42, HI=0.
- MULT A=0xFFFFFFFD (-3), B=5 -> Busy high for 33 cycles; Done pulses once exactly 33 edges after accept; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU 100/7 -> LO=0x0000000E, HI=0x00000002. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x00001234. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. Both at full latency.
- MTHI 0xDEADBEEF then MTLO 0xCAFEF00D on consecutive cycles -> HI/LO update the following edge each, Busy stays 0. An op issued while Busy (e.g. MTLO 0x1 at cycle 5 of a MULT) is ignored: LO equals the product result afterward.
- MULTU 0xFFFFFFFF*0xFFFFFFFF with Cancel at RUN cycle 20 -> Busy drops next cycle, no Done, HI/LO hold previous values. Reissue with no cancel -> HI=0xFFFFFFFE, LO=0x00000001.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: op issue / result bus between ID/EX and the multiply/divide unit.
//   Op_Valid, Op_Code, A, B, Cancel : issued by the pipeline (master)
//   Op_Ready, Busy, Done, HI, LO    : returned by the unit (slave)
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Op_Valid;
  logic [2:0]       Op_Code;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cancel;
  logic             Op_Ready;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Op_Valid, Op_Code, A, B, Cancel,
    input  Op_Ready, Busy, Done, HI, LO
  );

  modport slave (
    input  Op_Valid, Op_Code, A, B, Cancel,
    output Op_Ready, Busy, Done, HI, LO
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle radix-2 multiply/divide unit owning the HI/LO registers.
//   Clk   : pipeline clock
//   Reset : synchronous, active-low reset
//   bus   : op issue (Op_Valid, Op_Code, A, B, Cancel) and status/results
//           (Op_Ready, Busy, Done, HI, LO)
// Op_Code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
// A mult/div takes WIDTH iteration cycles plus one fixup cycle after acceptance.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic          Clk,
  input logic          Reset,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t state, state_nx;

  logic [CW-1:0]    counter;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic             div_zero;
  logic [WIDTH-1:0] opnd;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] lo_sh;     // multiplier/product-low or dividend/quotient
  logic [WIDTH:0]   acc;       // product-high or remainder
  logic [WIDTH-1:0] a_raw;     // original A, returned as HI on divide by zero
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  // Issue decode
  logic             op_md;
  logic             op_signed;
  logic             op_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    op_md     = bus.Op_Valid && !bus.Op_Code[2];
    op_signed = !bus.Op_Code[0];
    op_div    = bus.Op_Code[1];
    a_neg     = op_signed && bus.A[WIDTH-1];
    b_neg     = op_signed && bus.B[WIDTH-1];
    // The most negative value negates to itself, which read unsigned is its magnitude
    a_mag     = a_neg ? (WIDTH'(0) - bus.A) : bus.A;
    b_mag     = b_neg ? (WIDTH'(0) - bus.B) : bus.B;
  end

  // One iteration step and final sign fixups
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    mul_sum   = acc + (lo_sh[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[WIDTH-1:0], lo_sh[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift - {1'b0, opnd};
    prod      = {acc[WIDTH-1:0], lo_sh};
    prod_fix  = neg_res ? ((2*WIDTH)'(0) - prod) : prod;
    quo_fix   = neg_res ? (WIDTH'(0) - lo_sh) : lo_sh;
    rem_fix   = neg_rem ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (op_md) state_nx = RUN;
      RUN: begin
        if (bus.Cancel)           state_nx = IDLE;
        else if (counter == LAST) state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and HI/LO
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      counter  <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      lo_sh    <= '0;
      acc      <= '0;
      a_raw    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (op_md) begin
            counter  <= '0;
            acc      <= '0;
            is_div   <= op_div;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= op_div && (bus.B == '0);
            a_raw    <= bus.A;
            opnd     <= op_div ? b_mag : a_mag;
            lo_sh    <= op_div ? a_mag : b_mag;
          end else if (bus.Op_Valid && bus.Op_Code == 3'b100) begin
            hi_q <= bus.A;
          end else if (bus.Op_Valid && bus.Op_Code == 3'b101) begin
            lo_q <= bus.A;
          end
        end
        RUN: begin
          if (!bus.Cancel) begin
            if (is_div) begin
              // Restoring step: keep the subtraction only when it did not go negative
              acc   <= div_ge ? div_diff : div_shift;
              lo_sh <= {lo_sh[WIDTH-2:0], div_ge};
            end else begin
              // Shift-add: {acc, lo_sh} shifts right, product grows in from the top
              acc   <= {1'b0, mul_sum[WIDTH:1]};
              lo_sh <= {mul_sum[0], lo_sh[WIDTH-1:1]};
            end
            if (counter != LAST) counter <= counter + CW'(1);
          end
        end
        FIN: begin
          if (!bus.Cancel) begin
            if (is_div && div_zero) begin
              hi_q <= a_raw;
              lo_q <= '1;
            end else if (is_div) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy     = (state != IDLE);
  assign bus.Op_Ready = (state == IDLE);
  assign bus.Done     = done_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with a plain-arithmetic
// reference model, directed corner cases and randomized operands.
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          issue_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: results straight from 64-bit arithmetic and SV division rules
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint          p;
    longint unsigned pu;
    int              q;
    int              r;
    hi = '0;
    lo = '0;
    case (op)
      3'd0: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd1: begin
        pu = {32'd0, a} * {32'd0, b};
        hi = pu[63:32];
        lo = pu[31:0];
      end
      3'd2: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 32'd0;
          lo = 32'h8000_0000;
        end else begin
          q  = $signed(a) / $signed(b);
          r  = $signed(a) % $signed(b);
          hi = r;
          lo = q;
        end
      end
      3'd3: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
      default: ;
    endcase
  endfunction

  // Monitor: every Done pulse must match the oldest outstanding result
  always @(negedge clk) begin
    if (bus.Done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_hi", {32'd0, bus.HI}, {32'd0, e.hi});
        chk("done_lo", {32'd0, bus.LO}, {32'd0, e.lo});
        chk("done_latency", 64'(cyc - e.issue_cyc), 64'd34);
      end
    end
  end

  // mode: 0 normal, 1 cancel at busy cycle 'at', 2 reset at 'at', 3 MTLO while busy at 'at'
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int mode, input int at);
    logic [31:0] eh;
    logic [31:0] el;
    exp_t        e;
    int          n;
    model(op, a, b, eh, el);
    @(negedge clk);
    bus.Op_Valid = 1'b1;
    bus.Op_Code  = op;
    bus.A        = a;
    bus.B        = b;
    if (mode == 0 || mode == 3) begin
      e.hi        = eh;
      e.lo        = el;
      e.issue_cyc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.Op_Valid = 1'b0;
    n = 0;
    while (bus.Busy && n < 40) begin
      n++;
      if (mode == 1 && n == at) bus.Cancel = 1'b1;
      if (mode == 2 && n == at) rst_n = 1'b0;
      if (mode == 3 && n == at) begin
        bus.Op_Valid = 1'b1;
        bus.Op_Code  = 3'b101;
        bus.A        = 32'h1;
      end
      @(negedge clk);
      bus.Cancel   = 1'b0;
      bus.Op_Valid = 1'b0;
      rst_n        = 1'b1;
    end
    if (mode == 0 || mode == 3) begin
      chk("busy_cycles", 64'(n), 64'd33);
      m_hi = eh;
      m_lo = el;
    end else begin
      chk("busy_until_abort", 64'(n), 64'(at));
      chk("no_done_after_abort", {63'd0, bus.Done}, 64'd0);
      if (mode == 2) begin
        m_hi = '0;
        m_lo = '0;
      end
    end
    chk("hi_after_op", {32'd0, bus.HI}, {32'd0, m_hi});
    chk("lo_after_op", {32'd0, bus.LO}, {32'd0, m_lo});
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    n_checks     = 0;
    n_fail       = 0;
    m_hi         = '0;
    m_lo         = '0;
    rst_n        = 1'b0;
    bus.Op_Valid = 1'b0;
    bus.Op_Code  = '0;
    bus.A        = '0;
    bus.B        = '0;
    bus.Cancel   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", {63'd0, bus.Busy}, 64'd0);
    chk("reset_ready", {63'd0, bus.Op_Ready}, 64'd1);
    chk("reset_done", {63'd0, bus.Done}, 64'd0);
    chk("reset_hi", {32'd0, bus.HI}, 64'd0);
    chk("reset_lo", {32'd0, bus.LO}, 64'd0);

    // Reset mid-divide, then a clean multiply
    run_op(3'd3, 32'd100, 32'd7, 2, 10);
    chk("post_reset_busy", {63'd0, bus.Busy}, 64'd0);
    run_op(3'd1, 32'd6, 32'd7, 0, 0);

    // Directed results and corner cases
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 0, 0);
    run_op(3'd3, 32'd100, 32'd7, 0, 0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(3'd3, 32'h0000_1234, 32'd0, 0, 0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd2, 32'hFFFF_FFFB, 32'd0, 0, 0);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 0, 0);

    // MTHI then MTLO on consecutive cycles
    @(negedge clk);
    bus.Op_Valid = 1'b1;
    bus.Op_Code  = 3'b100;
    bus.A        = 32'hDEAD_BEEF;
    bus.Cancel   = 1'b1;
    @(negedge clk);
    chk("mthi_hi", {32'd0, bus.HI}, 64'h0000_0000_DEAD_BEEF);
    chk("mthi_busy", {63'd0, bus.Busy}, 64'd0);
    bus.Op_Code = 3'b101;
    bus.A       = 32'hCAFE_F00D;
    bus.Cancel  = 1'b0;
    @(negedge clk);
    chk("mtlo_lo", {32'd0, bus.LO}, 64'h0000_0000_CAFE_F00D);
    chk("mtlo_hi_kept", {32'd0, bus.HI}, 64'h0000_0000_DEAD_BEEF);
    chk("mtlo_busy", {63'd0, bus.Busy}, 64'd0);
    bus.Op_Code = 3'b110;
    bus.A       = 32'h5555_5555;
    @(negedge clk);
    bus.Op_Valid = 1'b0;
    chk("noop_busy", {63'd0, bus.Busy}, 64'd0);
    chk("noop_hi", {32'd0, bus.HI}, 64'h0000_0000_DEAD_BEEF);
    chk("noop_lo", {32'd0, bus.LO}, 64'h0000_0000_CAFE_F00D);
    m_hi = 32'hDEAD_BEEF;
    m_lo = 32'hCAFE_F00D;

    // Op presented while busy must be dropped
    run_op(3'd0, 32'd1234, 32'hFFFF_FF00, 3, 5);

    // Cancel mid-run keeps HI/LO, then reissue to completion
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 20);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 33);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);

    // Randomized operands
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      run_op(rop, ra, rb, 0, 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
